gpr_file_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the single-cycle core and its pipelined follow-on. It supersedes the fixed 2-read/1-write file. New in this block: configurable read/write port counts and register depth, optional write-to-read bypass, a per-register pending (scoreboard) bit for long-latency producers, and a sequenced zero-clear of the array after reset or on flush. It sits between decode (read ports, scoreboard set) and writeback (write ports).

---
 rtl/gpr_file_mp_if.sv | 30 +++
 rtl/gpr_file_mp.sv | 116 +++++++++++
 tb/tb_gpr_file_mp.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_file_mp_if.sv
// Bus bundle for gpr_file_mp: write ports, read ports, scoreboard set, flush and init status.
// Decode/writeback drive the master side; the register file takes the slave side.
interface gpr_file_mp_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NWR  = 1
);
    logic                flush_i;
    logic                init_busy_o;
    logic [NWR-1:0]      wen_i;
    logic [NWR*AW-1:0]   waddr_i;
    logic [NWR*XLEN-1:0] wdata_i;
    logic [NRD-1:0]      ren_i;
    logic [NRD*AW-1:0]   raddr_i;
    logic [NRD*XLEN-1:0] rdata_o;
    logic [NRD-1:0]      rbusy_o;
    logic                pset_i;
    logic [AW-1:0]       pset_addr_i;

    modport master (
        output flush_i, wen_i, waddr_i, wdata_i, ren_i, raddr_i, pset_i, pset_addr_i,
        input  init_busy_o, rdata_o, rbusy_o
    );

    modport slave (
        input  flush_i, wen_i, waddr_i, wdata_i, ren_i, raddr_i, pset_i, pset_addr_i,
        output init_busy_o, rdata_o, rbusy_o
    );
endinterface

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file with x0 hard-wired to zero, optional write-to-read bypass,
// per-register pending bits and a one-register-per-cycle zero-clear after reset or flush.
module gpr_file_mp #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic         reg_clk_i,
    input  logic         reg_rst_i,
    gpr_file_mp_if.slave bus
);
    localparam int AW = $clog2(NREG);

    generate
        if (XLEN < 1 || NREG < 2 || (NREG & (NREG - 1)) != 0 ||
            NRD < 1 || NRD > 4 || NWR < 1 || NWR > 2 ||
            (BYPASS != 0 && BYPASS != 1)) begin : g_bad_param
            $error("gpr_file_mp: parameter out of range");
        end
    endgenerate

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_pend;

    logic            w_run;
    logic [NWR-1:0]  w_wr_acc;
    logic [AW-1:0]   w_waddr [NWR];
    logic [XLEN-1:0] w_wdata [NWR];
    logic [AW-1:0]   w_raddr [NRD];
    logic [XLEN-1:0] w_rdata [NRD];
    logic [NRD-1:0]  w_rbusy;

    assign w_run           = (r_state == ST_RUN);
    assign bus.init_busy_o = (r_state == ST_INIT);
    assign bus.rbusy_o     = w_rbusy;

    for (genvar k = 0; k < NWR; k++) begin : g_wr
        assign w_waddr[k]  = bus.waddr_i[k*AW +: AW];
        assign w_wdata[k]  = bus.wdata_i[k*XLEN +: XLEN];
        assign w_wr_acc[k] = w_run && bus.wen_i[k] && (w_waddr[k] != '0);
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign w_raddr[k]                   = bus.raddr_i[k*AW +: AW];
        assign bus.rdata_o[k*XLEN +: XLEN] = w_rdata[k];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
    always_ff @(posedge reg_clk_i or posedge reg_rst_i) begin
        if (reg_rst_i) begin
            r_state <= ST_INIT;
            r_cnt   <= AW'(1);
            r_pend  <= '0;
        end else if (bus.flush_i) begin
            r_state <= ST_INIT;
            r_cnt   <= AW'(1);
        end else if (r_state == ST_INIT) begin
            r_pend[r_cnt] <= 1'b0;
            if (r_cnt == AW'(NREG - 1)) begin
                r_state <= ST_RUN;
            end else begin
                r_cnt <= r_cnt + AW'(1);
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (w_wr_acc[k]) begin
                    r_pend[w_waddr[k]] <= 1'b0;
                end
            end
            // A new producer issued on the same edge outranks the retiring write.
            if (bus.pset_i && (bus.pset_addr_i != '0)) begin
                r_pend[bus.pset_addr_i] <= 1'b1;
            end
        end
    end

    // NOTE: the array has no reset; the clear sequence zeroes it, so it maps onto plain RAM/flops.
    always_ff @(posedge reg_clk_i) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= '0;
        end else begin
            // Later ports are applied last, so the highest-index port wins an address clash.
            for (int k = 0; k < NWR; k++) begin
                if (w_wr_acc[k]) begin
                    r_mem[w_waddr[k]] <= w_wdata[k];
                end
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            w_rdata[k] = '0;
            w_rbusy[k] = 1'b0;
            if (w_run && bus.ren_i[k] && (w_raddr[k] != '0)) begin
                w_rdata[k] = r_mem[w_raddr[k]];
                w_rbusy[k] = r_pend[w_raddr[k]];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (w_wr_acc[j] && (w_waddr[j] == w_raddr[k])) begin
                            w_rdata[k] = w_wdata[j];
                            w_rbusy[k] = 1'b0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gpr_file_mp.sv
// Bench for gpr_file_mp: a 2-write bypassing instance and a 1-write non-bypassing instance,
// checked against a per-register array model with a countdown for the clear sequence.
module tb_gpr_file_mp;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    gpr_file_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(2)) if_a ();
    gpr_file_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(1)) if_b ();

    gpr_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(2), .BYPASS(1)) u_dut_a (
        .reg_clk_i (clk),
        .reg_rst_i (rst),
        .bus       (if_a)
    );

    gpr_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(1), .BYPASS(0)) u_dut_b (
        .reg_clk_i (clk),
        .reg_rst_i (rst),
        .bus       (if_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected the run to complete");
        $fatal(1);
    end

    // Reference model: register contents, pending flags and cycles of clearing still to go.
    logic [63:0] m_mem  [2][NREG];
    bit          m_pend [2][NREG];
    int          m_left [2];

    typedef struct packed {
        bit [1:0]   wen;
        bit [9:0]   wa;
        bit [127:0] wd;
        bit [1:0]   ren;
        bit [9:0]   ra;
        bit         pset;
        bit [4:0]   pa;
        bit         flush;
    } stim_t;

    function automatic stim_t cur(input int d);
        stim_t s;
        if (d == 0) begin
            s.wen = if_a.wen_i;  s.wa = if_a.waddr_i; s.wd = if_a.wdata_i;
            s.ren = if_a.ren_i;  s.ra = if_a.raddr_i;
            s.pset = if_a.pset_i; s.pa = if_a.pset_addr_i; s.flush = if_a.flush_i;
        end else begin
            s.wen = {1'b0, if_b.wen_i}; s.wa = {5'd0, if_b.waddr_i}; s.wd = {64'd0, if_b.wdata_i};
            s.ren = if_b.ren_i;  s.ra = if_b.raddr_i;
            s.pset = if_b.pset_i; s.pa = if_b.pset_addr_i; s.flush = if_b.flush_i;
        end
        return s;
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            m_left[d] = NREG - 1;
            for (int r = 0; r < NREG; r++) m_pend[d][r] = 1'b0;
        end
    endfunction

    // Expected {init_busy, rbusy[1:0], rdata[127:0]} for the inputs currently driven.
    function automatic logic [130:0] exp_all(input int d);
        stim_t       s = cur(d);
        logic [127:0] rd = '0;
        logic [1:0]   rb = '0;
        int           a;
        if (m_left[d] == 0) begin
            for (int k = 0; k < 2; k++) begin
                a = int'(s.ra[k*5 +: 5]);
                if (s.ren[k] && a != 0) begin
                    rd[k*64 +: 64] = m_mem[d][a];
                    rb[k]          = m_pend[d][a];
                    if (d == 0) begin
                        for (int j = 0; j < 2; j++) begin
                            if (s.wen[j] && int'(s.wa[j*5 +: 5]) == a) begin
                                rd[k*64 +: 64] = s.wd[j*64 +: 64];
                                rb[k]          = 1'b0;
                            end
                        end
                    end
                end
            end
        end
        return {m_left[d] != 0, rb, rd};
    endfunction

    function automatic void m_edge(input int d);
        stim_t s = cur(d);
        int    nwr = (d == 0) ? 2 : 1;
        int    a;
        if (rst) return;
        if (m_left[d] != 0) begin
            if (s.flush) begin
                m_left[d] = NREG - 1;
            end else begin
                m_mem[d][NREG - m_left[d]]  = '0;
                m_pend[d][NREG - m_left[d]] = 1'b0;
                m_left[d]--;
            end
        end else begin
            for (int j = 0; j < nwr; j++) begin
                a = int'(s.wa[j*5 +: 5]);
                if (s.wen[j] && a != 0) begin
                    m_mem[d][a]  = s.wd[j*64 +: 64];
                    m_pend[d][a] = 1'b0;
                end
            end
            if (s.pset && s.pa != 0) m_pend[d][s.pa] = 1'b1;
            if (s.flush) m_left[d] = NREG - 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        m_edge(0);
        m_edge(1);
        #1;
    endtask

    task automatic set_idle();
        if_a.flush_i = 0; if_a.wen_i = 0; if_a.waddr_i = 0; if_a.wdata_i = 0;
        if_a.ren_i = 0; if_a.raddr_i = 0; if_a.pset_i = 0; if_a.pset_addr_i = 0;
        if_b.flush_i = 0; if_b.wen_i = 0; if_b.waddr_i = 0; if_b.wdata_i = 0;
        if_b.ren_i = 0; if_b.raddr_i = 0; if_b.pset_i = 0; if_b.pset_addr_i = 0;
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    task automatic rnd_in(input int flush_rate);
        if_a.wen_i = 2'($urandom_range(0, 3));
        if_a.waddr_i = {rnd_addr(), rnd_addr()};
        if_a.wdata_i = {$urandom, $urandom, $urandom, $urandom};
        if_a.ren_i = 2'($urandom_range(0, 3));
        if_a.raddr_i = {rnd_addr(), rnd_addr()};
        if_a.pset_i = ($urandom_range(0, 3) == 0);
        if_a.pset_addr_i = rnd_addr();
        if_a.flush_i = (flush_rate != 0) && ($urandom_range(1, flush_rate) == 1);
        if_b.wen_i = 1'($urandom_range(0, 1));
        if_b.waddr_i = rnd_addr();
        if_b.wdata_i = {$urandom, $urandom};
        if_b.ren_i = 2'($urandom_range(0, 3));
        if_b.raddr_i = {rnd_addr(), rnd_addr()};
        if_b.pset_i = ($urandom_range(0, 3) == 0);
        if_b.pset_addr_i = rnd_addr();
        if_b.flush_i = (flush_rate != 0) && ($urandom_range(1, flush_rate) == 1);
    endtask

    // Counts clear cycles, comparing both instances each cycle; ends at the first RUN negedge.
    task automatic count_clear(input string name);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({if_a.init_busy_o, if_a.rbusy_o, if_a.rdata_o} !== exp_all(0)) begin
                errors++;
                $display("FAIL %s_a cycle %0d: got %h, expected %h", name, i,
                         {if_a.init_busy_o, if_a.rbusy_o, if_a.rdata_o}, exp_all(0));
            end
            checks++;
            if ({if_b.init_busy_o, if_b.rbusy_o, if_b.rdata_o} !== exp_all(1)) begin
                errors++;
                $display("FAIL %s_b cycle %0d: got %h, expected %h", name, i,
                         {if_b.init_busy_o, if_b.rbusy_o, if_b.rdata_o}, exp_all(1));
            end
            if (!if_a.init_busy_o) break;
            n++;
            tick();
        end
        checks++;
        if (n != NREG - 1) begin
            errors++;
            $display("FAIL %s_length: got %0d busy cycles, expected %0d", name, n, NREG - 1);
        end
    endtask

    task automatic test_reset();
        set_idle();
        if_a.ren_i = 2'b11; if_a.raddr_i = {5'd5, 5'd3};
        if_b.ren_i = 2'b11; if_b.raddr_i = {5'd5, 5'd3};
        rst = 1'b1;
        m_reset();
        #2;
        checks++;
        if ({if_a.init_busy_o, if_a.rbusy_o, if_a.rdata_o, if_b.init_busy_o, if_b.rbusy_o, if_b.rdata_o}
            !== {1'b1, 130'd0, 1'b1, 130'd0}) begin
            errors++;
            $display("FAIL reset_state: got busy %b/%b rbusy %b/%b, expected busy 1/1 rbusy 00/00",
                     if_a.init_busy_o, if_b.init_busy_o, if_a.rbusy_o, if_b.rbusy_o);
        end
        tick();
        tick();
        rst = 1'b0;
        count_clear("reset_clear");
        tick();
        for (int r = 1; r < NREG; r++) begin
            if_a.raddr_i = {5'(r), 5'(r)};
            if_b.raddr_i = {5'(r), 5'(r)};
            @(negedge clk);
            checks++;
            if ({if_a.rbusy_o, if_a.rdata_o, if_b.rbusy_o, if_b.rdata_o} !== '0) begin
                errors++;
                $display("FAIL cleared_x%0d: got a=%h/%b b=%h/%b, expected all zero", r,
                         if_a.rdata_o, if_a.rbusy_o, if_b.rdata_o, if_b.rbusy_o);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        set_idle();
        if_a.wen_i = 2'b01; if_a.waddr_i = {5'd0, 5'd5}; if_a.wdata_i = {64'd0, 64'h1234};
        if_a.ren_i = 2'b01; if_a.raddr_i = {5'd0, 5'd5};
        if_b.wen_i = 1'b1;  if_b.waddr_i = 5'd5; if_b.wdata_i = 64'h1234;
        if_b.ren_i = 2'b01; if_b.raddr_i = {5'd0, 5'd5};
        @(negedge clk);
        checks++;
        if (if_a.rdata_o[63:0] !== 64'h1234) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h, expected 1234", if_a.rdata_o[63:0]);
        end
        checks++;
        if (if_b.rdata_o[63:0] !== 64'h0) begin
            errors++;
            $display("FAIL nobypass_same_cycle: got %h, expected 0", if_b.rdata_o[63:0]);
        end
        tick();
        if_a.wen_i = 0; if_b.wen_i = 0;
        @(negedge clk);
        checks++;
        if ({if_a.rdata_o[63:0], if_b.rdata_o[63:0]} !== {64'h1234, 64'h1234}) begin
            errors++;
            $display("FAIL write_next_cycle: got a=%h b=%h, expected 1234 1234",
                     if_a.rdata_o[63:0], if_b.rdata_o[63:0]);
        end
        tick();
    endtask

    task automatic test_dual_write();
        set_idle();
        if_a.wen_i = 2'b11; if_a.waddr_i = {5'd7, 5'd7}; if_a.wdata_i = {64'hBB, 64'hAA};
        if_a.ren_i = 2'b01; if_a.raddr_i = {5'd0, 5'd7};
        @(negedge clk);
        checks++;
        if (if_a.rdata_o[63:0] !== 64'hBB) begin
            errors++;
            $display("FAIL dual_write_bypass: got %h, expected bb", if_a.rdata_o[63:0]);
        end
        tick();
        if_a.wen_i = 2'b01; if_a.waddr_i = {5'd0, 5'd0}; if_a.wdata_i = {64'd0, 64'hFF};
        if_a.ren_i = 2'b11; if_a.raddr_i = {5'd7, 5'd0};
        @(negedge clk);
        checks++;
        if (if_a.rdata_o !== {64'hBB, 64'h0}) begin
            errors++;
            $display("FAIL x0_write_same_cycle: got %h, expected bb/0", if_a.rdata_o);
        end
        tick();
        if_a.wen_i = 2'b00;
        @(negedge clk);
        checks++;
        if (if_a.rdata_o !== {64'hBB, 64'h0}) begin
            errors++;
            $display("FAIL x0_write_next_cycle: got %h, expected bb/0", if_a.rdata_o);
        end
        tick();
    endtask

    task automatic test_pending();
        set_idle();
        if_a.pset_i = 1; if_a.pset_addr_i = 5'd9; if_a.ren_i = 2'b01; if_a.raddr_i = {5'd0, 5'd9};
        if_b.pset_i = 1; if_b.pset_addr_i = 5'd9; if_b.ren_i = 2'b01; if_b.raddr_i = {5'd0, 5'd9};
        @(negedge clk);
        checks++;
        if ({if_a.rbusy_o, if_b.rbusy_o} !== 4'b0000) begin
            errors++;
            $display("FAIL pset_same_cycle: got %b, expected 0000", {if_a.rbusy_o, if_b.rbusy_o});
        end
        tick();
        if_a.pset_i = 0; if_b.pset_i = 0;
        @(negedge clk);
        checks++;
        if ({if_a.rbusy_o, if_b.rbusy_o} !== 4'b0101) begin
            errors++;
            $display("FAIL pset_next_cycle: got %b, expected 0101", {if_a.rbusy_o, if_b.rbusy_o});
        end
        tick();
        if_a.wen_i = 2'b01; if_a.waddr_i = {5'd0, 5'd9}; if_a.wdata_i = {64'd0, 64'h99};
        if_b.wen_i = 1'b1;  if_b.waddr_i = 5'd9; if_b.wdata_i = 64'h99;
        @(negedge clk);
        checks++;
        if ({if_a.rbusy_o, if_b.rbusy_o} !== 4'b0001) begin
            errors++;
            $display("FAIL write_clear_same_cycle: got %b, expected 0001", {if_a.rbusy_o, if_b.rbusy_o});
        end
        tick();
        if_a.wen_i = 0; if_b.wen_i = 0;
        @(negedge clk);
        checks++;
        if ({if_a.rbusy_o, if_b.rbusy_o, if_a.rdata_o[63:0], if_b.rdata_o[63:0]}
            !== {4'b0000, 64'h99, 64'h99}) begin
            errors++;
            $display("FAIL write_clear_next_cycle: got busy %b data %h/%h, expected 0000 99/99",
                     {if_a.rbusy_o, if_b.rbusy_o}, if_a.rdata_o[63:0], if_b.rdata_o[63:0]);
        end
        tick();
        if_a.pset_i = 1; if_a.pset_addr_i = 5'd9; if_a.wen_i = 2'b01; if_a.wdata_i = {64'd0, 64'h5A};
        if_b.pset_i = 1; if_b.pset_addr_i = 5'd9; if_b.wen_i = 1'b1;  if_b.wdata_i = 64'h5A;
        tick();
        if_a.pset_i = 0; if_a.wen_i = 0; if_b.pset_i = 0; if_b.wen_i = 0;
        @(negedge clk);
        checks++;
        if ({if_a.rbusy_o, if_b.rbusy_o, if_a.rdata_o[63:0], if_b.rdata_o[63:0]}
            !== {4'b0101, 64'h5A, 64'h5A}) begin
            errors++;
            $display("FAIL pset_beats_write: got busy %b data %h/%h, expected 0101 5a/5a",
                     {if_a.rbusy_o, if_b.rbusy_o}, if_a.rdata_o[63:0], if_b.rdata_o[63:0]);
        end
        tick();
        if_a.pset_i = 1; if_a.pset_addr_i = 5'd0; if_a.ren_i = 2'b11;
        if_b.pset_i = 1; if_b.pset_addr_i = 5'd0; if_b.ren_i = 2'b11;
        tick();
        if_a.pset_i = 0; if_b.pset_i = 0;
        @(negedge clk);
        checks++;
        if ({if_a.rbusy_o, if_b.rbusy_o} !== 4'b0101) begin
            errors++;
            $display("FAIL pset_x0: got %b, expected 0101", {if_a.rbusy_o, if_b.rbusy_o});
        end
        tick();
    endtask

    task automatic test_flush();
        set_idle();
        if_a.wen_i = 2'b01; if_a.waddr_i = {5'd0, 5'd3}; if_a.wdata_i = {64'd0, 64'd5};
        if_a.pset_i = 1; if_a.pset_addr_i = 5'd3;
        if_b.wen_i = 1'b1; if_b.waddr_i = 5'd3; if_b.wdata_i = 64'd5;
        if_b.pset_i = 1; if_b.pset_addr_i = 5'd3;
        tick();
        set_idle();
        if_a.ren_i = 2'b01; if_a.raddr_i = {5'd0, 5'd3};
        if_b.ren_i = 2'b01; if_b.raddr_i = {5'd0, 5'd3};
        @(negedge clk);
        checks++;
        if ({if_a.rbusy_o, if_b.rbusy_o, if_a.rdata_o[63:0], if_b.rdata_o[63:0]}
            !== {4'b0101, 64'd5, 64'd5}) begin
            errors++;
            $display("FAIL preflush_x3: got busy %b data %h/%h, expected 0101 5/5",
                     {if_a.rbusy_o, if_b.rbusy_o}, if_a.rdata_o[63:0], if_b.rdata_o[63:0]);
        end
        if_a.flush_i = 1; if_b.flush_i = 1;
        tick();
        if_a.flush_i = 0; if_b.flush_i = 0;
        if_a.wen_i = 2'b11; if_a.waddr_i = {5'd3, 5'd3}; if_a.wdata_i = {64'h77, 64'h77};
        if_a.pset_i = 1;
        if_b.wen_i = 1'b1; if_b.wdata_i = 64'h77; if_b.pset_i = 1;
        count_clear("flush_clear");
        set_idle();
        if_a.ren_i = 2'b01; if_a.raddr_i = {5'd0, 5'd3};
        if_b.ren_i = 2'b01; if_b.raddr_i = {5'd0, 5'd3};
        #1;
        checks++;
        if ({if_a.rbusy_o, if_b.rbusy_o, if_a.rdata_o, if_b.rdata_o} !== '0) begin
            errors++;
            $display("FAIL postflush_x3: got busy %b data %h/%h, expected 0000 0/0",
                     {if_a.rbusy_o, if_b.rbusy_o}, if_a.rdata_o[63:0], if_b.rdata_o[63:0]);
        end
        tick();
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            rnd_in(150);
            @(negedge clk);
            checks++;
            if ({if_a.init_busy_o, if_a.rbusy_o, if_a.rdata_o} !== exp_all(0)) begin
                errors++;
                $display("FAIL random_a cycle %0d: got %h, expected %h", i,
                         {if_a.init_busy_o, if_a.rbusy_o, if_a.rdata_o}, exp_all(0));
            end
            checks++;
            if ({if_b.init_busy_o, if_b.rbusy_o, if_b.rdata_o} !== exp_all(1)) begin
                errors++;
                $display("FAIL random_b cycle %0d: got %h, expected %h", i,
                         {if_b.init_busy_o, if_b.rbusy_o, if_b.rdata_o}, exp_all(1));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_clear();
        set_idle();
        tick();
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        checks++;
        if ({if_a.init_busy_o, if_b.init_busy_o} !== 2'b11) begin
            errors++;
            $display("FAIL async_reset_run: got %b, expected 11", {if_a.init_busy_o, if_b.init_busy_o});
        end
        tick();
        rst = 1'b0;
        repeat (9) tick();
        @(negedge clk);
        checks++;
        if ({if_a.init_busy_o, if_b.init_busy_o} !== 2'b11) begin
            errors++;
            $display("FAIL busy_at_count10: got %b, expected 11", {if_a.init_busy_o, if_b.init_busy_o});
        end
        #1;
        rst = 1'b1;
        m_reset();
        #1;
        checks++;
        if ({if_a.init_busy_o, if_b.init_busy_o} !== 2'b11) begin
            errors++;
            $display("FAIL async_reset_clear: got %b, expected 11", {if_a.init_busy_o, if_b.init_busy_o});
        end
        tick();
        rst = 1'b0;
        count_clear("restart_clear");
        tick();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_pending();
        test_flush();
        test_random(500);
        test_reset_mid_clear();
        test_random(150);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
